conv_frame_sequencer: RTL and testbench

Frame-level controller for the convolution line buffer. It accepts a frame size, clears the line buffer between frames, and gates a ready/valid pixel stream into it. It also qualifies the buffer's window output, forwarding only full interior K×K windows, with window coordinates and backpressure, to the downstream MAC array.

---
 rtl/conv_frame_sequencer_if.sv | 61 ++++++
 rtl/conv_frame_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_frame_sequencer_if
//  Purpose  : Bundles the frame-control, pixel-stream, line-buffer and
//             window-output signals of the convolution frame sequencer.
//             slave  = sequencer view, master = environment view.
//  Ports    : start/abort/cfg_rows/cfg_cols   frame control
//             in_data/in_valid/in_ready        pixel stream (ready/valid)
//             buf_*                            line-buffer side
//             win_*                            qualified window to MAC array
//             busy/frame_done/cfg_err          status
//  Revision : 1.0  initial release
// ============================================================================
interface conv_frame_sequencer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_COLS    = 2000,
    parameter int MAX_ROWS    = 2000,
    parameter int KERNEL_SIZE = 3
);
    localparam int COL_W = $clog2(MAX_COLS);
    localparam int ROW_W = $clog2(MAX_ROWS);
    localparam int WIN_W = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

    logic                  start;
    logic                  abort;
    logic [ROW_W-1:0]      cfg_rows;
    logic [COL_W-1:0]      cfg_cols;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] buf_point;
    logic                  buf_valid_in;
    logic [COL_W-1:0]      buf_frame_column_size;
    logic                  buf_rst_n;
    logic [WIN_W-1:0]      buf_window;
    logic [WIN_W-1:0]      win_data;
    logic [ROW_W-1:0]      win_row;
    logic [COL_W-1:0]      win_col;
    logic                  win_valid;
    logic                  win_ready;
    logic                  busy;
    logic                  frame_done;
    logic                  cfg_err;

    modport slave (
        input  start, abort, cfg_rows, cfg_cols, in_data, in_valid,
               buf_window, win_ready,
        output in_ready, buf_point, buf_valid_in, buf_frame_column_size,
               buf_rst_n, win_data, win_row, win_col, win_valid,
               busy, frame_done, cfg_err
    );

    modport master (
        output start, abort, cfg_rows, cfg_cols, in_data, in_valid,
               buf_window, win_ready,
        input  in_ready, buf_point, buf_valid_in, buf_frame_column_size,
               buf_rst_n, win_data, win_row, win_col, win_valid,
               busy, frame_done, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_frame_sequencer
//  Purpose  : Frame-level controller for the convolution line buffer.
//             Latches a frame size, clears the line buffer between frames,
//             gates the pixel stream into it and forwards only full interior
//             KxK windows (with top-left coordinates) downstream.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - conv_frame_sequencer_if.slave (control, pixel stream,
//                    line-buffer side, window output, status)
//  Revision : 1.0  initial release
// ============================================================================
module conv_frame_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_COLS    = 2000,
    parameter int MAX_ROWS    = 2000,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_frame_sequencer_if.slave bus
);
    localparam int COL_W = $clog2(MAX_COLS);
    localparam int ROW_W = $clog2(MAX_ROWS);
    localparam int WIN_W = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

    localparam logic [ROW_W-1:0] c_K_ROW    = ROW_W'(KERNEL_SIZE);
    localparam logic [COL_W-1:0] c_K_COL    = COL_W'(KERNEL_SIZE);
    localparam logic [ROW_W-1:0] c_KM1_ROW  = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] c_KM1_COL  = COL_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] c_MAX_COLS = COL_W'(MAX_COLS);
    localparam logic [ROW_W-1:0] c_ONE_ROW  = ROW_W'(1);
    localparam logic [COL_W-1:0] c_ONE_COL  = COL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ROW_W-1:0] r_rows;
    logic [COL_W-1:0] r_cols;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_win_row;
    logic [COL_W-1:0] r_win_col;
    logic             r_win_valid;
    logic             r_abort_q;
    logic             r_cfg_err;

    logic             w_abort_act;
    logic             w_cfg_ok;
    logic             w_in_ready;
    logic             w_push;
    logic             w_win_gen;
    logic             w_last_pix;
    logic             w_start_ok;
    logic             w_cfg_bad;
    logic             w_frame_done;
    logic [WIN_W-1:0] w_window;

    // abort only matters once a frame is in flight
    assign w_abort_act = bus.abort && (r_state != S_IDLE);

    assign w_cfg_ok = (bus.cfg_rows >= c_K_ROW) &&
                      (bus.cfg_cols >= c_K_COL) &&
                      (bus.cfg_cols <= c_MAX_COLS);

    // A pending window blocks further pushes because the line buffer shifts
    // on every push and the window output is a live view of it.
    assign w_in_ready = (r_state == S_STREAM) &&
                        (!r_win_valid || bus.win_ready) && !bus.abort;
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_win_gen  = w_push && (r_row >= c_KM1_ROW) && (r_col >= c_KM1_COL);
    assign w_last_pix = (r_row == r_rows - c_ONE_ROW) &&
                        (r_col == r_cols - c_ONE_COL);
    assign w_window   = bus.buf_window;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_ok   = 1'b0;
        w_cfg_bad    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (w_cfg_ok) begin
                        w_state_nxt = S_CLEAR;
                        w_start_ok  = 1'b1;
                    end else begin
                        w_cfg_bad = 1'b1;
                    end
                end
            end
            S_CLEAR:  w_state_nxt = S_STREAM;
            S_STREAM: if (w_push && w_last_pix) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                // exit once the final window is taken (or none is pending)
                if (!r_win_valid || bus.win_ready) begin
                    w_state_nxt  = S_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_abort_act) begin
            w_state_nxt  = S_IDLE;
            w_frame_done = 1'b0;
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rows      <= '0;
            r_cols      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_win_valid <= 1'b0;
            r_abort_q   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_abort_q <= bus.abort;
            r_cfg_err <= w_cfg_bad;

            if (w_start_ok) begin
                r_rows <= bus.cfg_rows;
                r_cols <= bus.cfg_cols;
            end

            if (r_state == S_CLEAR) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_push) begin
                if (r_col == r_cols - c_ONE_COL) begin
                    r_col <= '0;
                    r_row <= r_row + c_ONE_ROW;
                end else begin
                    r_col <= r_col + c_ONE_COL;
                end
            end

            // a fresh window replaces an accepted one without a bubble
            if (w_abort_act) begin
                r_win_valid <= 1'b0;
            end else if (w_win_gen) begin
                r_win_valid <= 1'b1;
                r_win_row   <= r_row - c_KM1_ROW;
                r_win_col   <= r_col - c_KM1_COL;
            end else if (bus.win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------- outputs
    assign bus.in_ready              = w_in_ready;
    assign bus.buf_point             = bus.in_data;
    assign bus.buf_valid_in          = w_push;
    assign bus.buf_frame_column_size = r_cols;
    assign bus.buf_rst_n             = !(rst || (r_state == S_CLEAR) || r_abort_q);
    assign bus.win_data              = w_window;
    assign bus.win_row               = r_win_row;
    assign bus.win_col               = r_win_col;
    assign bus.win_valid             = r_win_valid;
    assign bus.busy                  = (r_state != S_IDLE);
    assign bus.frame_done            = w_frame_done;
    assign bus.cfg_err               = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_frame_sequencer
//  Purpose  : Directed testbench for conv_frame_sequencer with a behavioural
//             line buffer, a cycle model of the control outputs and a window
//             scoreboard (expected windows queued at push time).
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_frame_sequencer;
    localparam int DW = 8;
    localparam int K  = 3;
    localparam int MC = 2000;
    localparam int MR = 2000;
    localparam int WW = K * K * DW;
    localparam int LB = 32;

    localparam int ST_IDLE   = 0;
    localparam int ST_CLEAR  = 1;
    localparam int ST_STREAM = 2;
    localparam int ST_DRAIN  = 3;

    typedef struct {
        int            row;
        int            col;
        logic [WW-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    conv_frame_sequencer_if #(.DATA_WIDTH(DW), .MAX_COLS(MC), .MAX_ROWS(MR), .KERNEL_SIZE(K)) bus();

    conv_frame_sequencer #(.DATA_WIDTH(DW), .MAX_COLS(MC), .MAX_ROWS(MR), .KERNEL_SIZE(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------- behavioural line buffer
    logic [DW-1:0] lb [0:LB-1];
    logic [WW-1:0] lb_win;
    int            lb_age;

    always @(posedge clk) begin
        if (!bus.buf_rst_n) begin
            for (int i = 0; i < LB; i++) lb[i] <= '0;
        end else if (bus.buf_valid_in) begin
            lb[0] <= bus.buf_point;
            for (int i = 1; i < LB; i++) lb[i] <= lb[i-1];
        end
    end

    // window element (i,j) is at bits [(i*K+j)*DW +: DW], (0,0) = top-left
    always_comb begin
        lb_win = '0;
        lb_age = 0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                lb_age = (K-1-i) * int'(bus.buf_frame_column_size) + (K-1-j);
                if (lb_age < LB) lb_win[(i*K+j)*DW +: DW] = lb[lb_age];
            end
        end
    end
    assign bus.buf_window = lb_win;

    // ------------------------------------------------------ bench state
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    int m_state = ST_IDLE;
    bit m_wv = 0, m_abq = 0, m_cerr = 0;
    int m_rows = 0, m_cols = 0, m_cols_l = 0;
    int mpr = 0, mpc = 0, pushed = 0;
    int g_seed = 0, g_mode = 0;
    bit g_valid_en = 0, g_done_seen = 0;
    int win_cnt = 0, done_cnt = 0, cerr_cnt = 0;
    int last_push_cyc = -1, done_cyc = -1, p22_cyc = -1, first_wv_cyc = -1;

    function automatic logic [DW-1:0] pix(int seed, int r, int c);
        return DW'(seed * 37 + r * 16 + c * 3 + 1);
    endfunction

    function automatic logic [WW-1:0] golden(int seed, int r0, int c0);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[(i*K+j)*DW +: DW] = pix(seed, r0 + i, c0 + j);
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: entered at a falling edge with start/abort/cfg already
    // set by the caller; returns at the next falling edge.
    task automatic step();
        exp_t e;
        bit   m_ready, m_push, m_done, m_brst, push_win, last, cfg_ok;
        int   nx_state;
        bit   nx_wv, nx_cerr;

        bus.in_valid  = g_valid_en && (pushed < m_rows * m_cols);
        bus.in_data   = pix(g_seed, mpr, mpc);
        bus.win_ready = (g_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        #1;
        m_ready = (m_state == ST_STREAM) && (!m_wv || bus.win_ready) && !bus.abort;
        m_push  = bus.in_valid && m_ready;
        m_done  = (m_state == ST_DRAIN) && !bus.abort && (!m_wv || bus.win_ready);
        m_brst  = !((m_state == ST_CLEAR) || m_abq);

        check("in_ready", bus.in_ready, m_ready);
        check("buf_valid_in", bus.buf_valid_in, m_push);
        check("busy", bus.busy, m_state != ST_IDLE);
        check("win_valid", bus.win_valid, m_wv);
        check("frame_done", bus.frame_done, m_done);
        check("buf_rst_n", bus.buf_rst_n, m_brst);
        check("cfg_err", bus.cfg_err, m_cerr);
        check("buf_cols", bus.buf_frame_column_size, m_cols_l);

        if (bus.win_valid && first_wv_cyc < 0) first_wv_cyc = cyc;
        if (bus.win_valid && bus.win_ready) win_cnt++;
        if (bus.cfg_err) cerr_cnt++;

        if (m_wv) begin
            check("win_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("win_row", bus.win_row, exp_q[0].row);
                check("win_col", bus.win_col, exp_q[0].col);
                check("win_data", bus.win_data, exp_q[0].data);
                if (bus.win_ready) void'(exp_q.pop_front());
            end
        end

        push_win = 0;
        last     = 0;
        if (m_push) begin
            if (mpr >= K-1 && mpc >= K-1) begin
                push_win = 1;
                e.row  = mpr - (K-1);
                e.col  = mpc - (K-1);
                e.data = golden(g_seed, e.row, e.col);
                exp_q.push_back(e);
            end
            if (mpr == K-1 && mpc == K-1) p22_cyc = cyc;
            last = (mpr == m_rows-1) && (mpc == m_cols-1);
            if (last) last_push_cyc = cyc;
            pushed++;
            if (mpc == m_cols-1) begin mpc = 0; mpr++; end
            else mpc++;
        end
        if (m_done) begin
            done_cnt++;
            done_cyc    = cyc;
            g_done_seen = 1;
        end

        nx_state = m_state;
        nx_wv    = m_wv;
        nx_cerr  = 0;
        cfg_ok   = (bus.cfg_rows >= K) && (bus.cfg_cols >= K) && (bus.cfg_cols <= MC);
        if (bus.abort && m_state != ST_IDLE) begin
            nx_state = ST_IDLE;
            nx_wv    = 0;
            exp_q.delete();
        end else begin
            if (push_win) nx_wv = 1;
            else if (bus.win_ready) nx_wv = 0;
            case (m_state)
                ST_IDLE: if (bus.start && !bus.abort) begin
                    if (cfg_ok) begin
                        nx_state = ST_CLEAR;
                        m_rows   = int'(bus.cfg_rows);
                        m_cols   = int'(bus.cfg_cols);
                        m_cols_l = m_cols;
                        pushed   = 0; mpr = 0; mpc = 0;
                    end else begin
                        nx_cerr = 1;
                    end
                end
                ST_CLEAR:  nx_state = ST_STREAM;
                ST_STREAM: if (last) nx_state = ST_DRAIN;
                default:   if (m_done) nx_state = ST_IDLE;
            endcase
        end
        m_abq = bus.abort;
        @(negedge clk);
        cyc++;
        m_state = nx_state;
        m_wv    = nx_wv;
        m_cerr  = nx_cerr;
    endtask

    task automatic do_start(input int rows, input int cols, input int seed, input int mode);
        bus.cfg_rows = 11'(rows);
        bus.cfg_cols = 11'(cols);
        bus.start    = 1'b1;
        g_seed       = seed;
        g_mode       = mode;
        g_valid_en   = 1'b1;
        g_done_seen  = 1'b0;
        win_cnt      = 0;
        first_wv_cyc = -1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!g_done_seen && n < budget) begin step(); n++; end
        check(tag, g_done_seen, 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_pushes(input int target, input int budget);
        int n;
        n = 0;
        while (pushed < target && n < budget) begin step(); n++; end
        check("push_target", pushed, target);
    endtask

    task automatic reset_checks();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_buf_valid_in", bus.buf_valid_in, 0);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_buf_rst_n", bus.buf_rst_n, 0);
        check("rst_win_row", bus.win_row, 0);
        check("rst_win_col", bus.win_col, 0);
        check("rst_buf_cols", bus.buf_frame_column_size, 0);
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        #1;
        reset_checks();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_state = ST_IDLE; m_wv = 0; m_abq = 0; m_cerr = 0;
        m_cols_l = 0; m_rows = 0; m_cols = 0; pushed = 0;
        g_valid_en = 0;
        exp_q.delete();
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.cfg_rows = '0; bus.cfg_cols = '0;
        bus.in_data = '0; bus.in_valid = 0; bus.win_ready = 0;
        @(negedge clk);
        hold_reset();
        step();

        // 5x5, free-running
        do_start(5, 5, 1, 0);
        run_to_done("A_done", 60);
        check("A_windows", win_cnt, 9);
        check("A_first_win_latency", first_wv_cyc - p22_cyc, 1);
        check("A_done_latency", done_cyc - last_push_cyc, 1);
        step();

        // 5x5, win_ready toggling 1-0-0
        do_start(5, 5, 2, 1);
        run_to_done("B_done", 150);
        check("B_windows", win_cnt, 9);
        step();

        // rejected configuration
        bus.cfg_rows = 11'd5;
        bus.cfg_cols = 11'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        check("C_cfg_err_pulses", cerr_cnt, 1);

        // abort after 12 pixels, then a 4x6 frame
        d0 = done_cnt;
        do_start(5, 5, 3, 0);
        run_pushes(12, 40);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        g_valid_en = 0;
        repeat (3) step();
        check("D_no_done_on_abort", done_cnt, d0);
        do_start(4, 6, 4, 0);
        run_to_done("D2_done", 60);
        check("D2_windows", win_cnt, 8);

        // back-to-back 4x4 then 6x3
        do_start(4, 4, 5, 0);
        run_to_done("E1_done", 60);
        check("E1_windows", win_cnt, 4);
        do_start(6, 3, 6, 0);
        run_to_done("E2_done", 60);
        check("E2_windows", win_cnt, 4);
        step();

        // asynchronous reset mid-stream, then a 3x3 frame
        do_start(5, 5, 7, 0);
        run_pushes(14, 40);
        check("F_win_valid_before_rst", bus.win_valid, 1);
        hold_reset();
        step();
        do_start(3, 3, 8, 0);
        run_to_done("F2_done", 40);
        check("F2_windows", win_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
